// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler.
//   UART_DATA_W    default byte width of the transmit path
//   sched_state_e  scheduler FSM states (IDLE/LAUNCH/WAIT_ACK/WAIT_DONE)
//   rr_next        wrap-around increment used for the round-robin pointer
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_e;

    // Next requester index after idx, wrapping from n-1 back to 0.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the winner is the first requester whose bit
// is set, scanning upward from the pointer and wrapping past NUM_REQ-1.
// Ports:
//   req_i    NUM_REQ            request vector
//   ptr_i    $clog2(NUM_REQ)    index that has first claim this round
//   grant_o  NUM_REQ            one-hot grant (all zero when nothing requests)
//   idx_o    $clog2(NUM_REQ)    index of the granted requester
//   valid_o  1                  at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);

    localparam int IDW = $clog2(NUM_REQ);

    // Walk the candidates in priority order starting at the pointer; the
    // first requesting candidate wins and later ones are ignored via valid_o.
    always_comb begin
        int               cand;
        logic [IDW-1:0]   cand_idx;
        grant_o  = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o           = 1'b1;
                idx_o             = cand_idx;
                grant_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// sources. A grant is held for a burst of up to MAX_BURST bytes; bytes are
// paced off the transmitter's tx_busy, and a missing busy response is
// reported through ack_err. All outputs are registered.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   req_valid  per-requester byte pending
//   req_data   per-requester byte, requester i at [i*DATA_W +: DATA_W]
//   req_last   per-requester last-byte-of-burst flag
//   req_ready  one-cycle pulse: byte of requester i consumed
//   tx_data    byte to transmitter, held until the next tx_start
//   tx_start   one-cycle launch pulse to transmitter
//   tx_busy    transmitter busy (start bit .. stop bit)
//   grant_id   current / most recent granted requester
//   active     a grant is held
//   ack_err    one-cycle pulse: tx_busy did not rise within ACK_TO cycles
// ---------------------------------------------------------------------------
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = UART_DATA_W,
    parameter int MAX_BURST = 4,
    parameter int ACK_TO    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        active,
    output logic                        ack_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);
    localparam int TW  = $clog2(ACK_TO + 1);

    sched_state_e          state_q;
    logic [IDW-1:0]        rr_ptr_q;
    logic [IDW-1:0]        grant_id_q;
    logic                  active_q;
    logic [CW-1:0]         count_q;
    logic [TW-1:0]         timer_q;
    logic                  last_q;
    logic [DATA_W-1:0]     tx_data_q;
    logic                  tx_start_q;
    logic [NUM_REQ-1:0]    req_ready_q;
    logic                  ack_err_q;

    logic [NUM_REQ-1:0]    arb_grant;
    logic [IDW-1:0]        arb_idx;
    logic                  arb_valid;

    logic [IDW-1:0]        sel_idx;
    logic [DATA_W-1:0]     sel_data;
    logic                  sel_last;
    logic [NUM_REQ-1:0]    holder_onehot;
    logic [IDW-1:0]        rr_ptr_d;
    logic [CW-1:0]         count_d;
    logic                  burst_more;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Byte capture source: the fresh arbitration winner when idle, otherwise
    // the current holder continuing its burst. Also precomputes the pointer
    // after release and whether the holder may send another byte.
    always_comb begin
        sel_idx       = (state_q == ST_IDLE) ? arb_idx : grant_id_q;
        sel_data      = req_data[int'(sel_idx)*DATA_W +: DATA_W];
        sel_last      = req_last[sel_idx];
        holder_onehot = '0;
        holder_onehot[grant_id_q] = 1'b1;
        rr_ptr_d      = IDW'(rr_next(32'(grant_id_q), NUM_REQ));
        count_d       = count_q + 1'b1;
        burst_more    = req_valid[grant_id_q] && !last_q && (count_q < CW'(MAX_BURST));
    end

    // Scheduler FSM. Pulse outputs default low each cycle and are raised only
    // on the edge that makes the corresponding decision, so they come out as
    // single registered pulses. A release always passes through IDLE, which
    // guarantees at least one idle cycle between bursts; grant_id is left at
    // its last value so it still names the most recent holder.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            active_q    <= 1'b0;
            count_q     <= '0;
            timer_q     <= '0;
            last_q      <= 1'b0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            ack_err_q   <= 1'b0;
        end else begin
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            ack_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_id_q  <= arb_idx;
                        active_q    <= 1'b1;
                        count_q     <= CW'(1);
                        last_q      <= sel_last;
                        tx_data_q   <= sel_data;
                        tx_start_q  <= 1'b1;
                        req_ready_q <= arb_grant;
                        state_q     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (timer_q == TW'(ACK_TO - 1)) begin
                        ack_err_q <= 1'b1;
                        active_q  <= 1'b0;
                        rr_ptr_q  <= rr_ptr_d;
                        state_q   <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (burst_more) begin
                            count_q     <= count_d;
                            last_q      <= sel_last;
                            tx_data_q   <= sel_data;
                            tx_start_q  <= 1'b1;
                            req_ready_q <= holder_onehot;
                            state_q     <= ST_LAUNCH;
                        end else begin
                            active_q <= 1'b0;
                            rr_ptr_q <= rr_ptr_d;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign grant_id  = grant_id_q;
    assign active    = active_q;
    assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
// Bench for uart_tx_sched: queue-based requesters, a transmitter model whose
// busy rises one cycle after tx_start and stays high 10 cycles, a cycle-level
// behavioural model compared against every output each cycle, directed
// scenarios with literal expectations, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
    localparam int ACK_TO    = 16;
    localparam int BUSY_LEN  = 10;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_last = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy = 1'b0;
    logic [1:0]                grant_id;
    logic                      active;
    logic                      ack_err;

    int testsRun = 0;
    int testsFailed = 0;

    uart_tx_sched #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .ACK_TO    (ACK_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active),
        .ack_err   (ack_err)
    );

    always #5 clk = ~clk;

    // Per-requester pending bytes as {last, data}; a hold-off gap after each
    // consumed byte lets the random phase drop req_valid between bytes.
    logic [8:0] reqQ [NUM_REQ][$];
    int         gapLeft [NUM_REQ];
    bit         gapMode = 1'b0;
    bit         busyEnable = 1'b1;
    int         busyLeft = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reqQ[i].size() > 0 && gapLeft[i] == 0) begin
                req_valid[i]                 = 1'b1;
                req_data[i*DATA_W +: DATA_W] = reqQ[i][0][7:0];
                req_last[i]                  = reqQ[i][0][8];
            end else begin
                req_valid[i]                 = 1'b0;
                req_data[i*DATA_W +: DATA_W] = '0;
                req_last[i]                  = 1'b0;
            end
        end
    endtask

    // Requesters and transmitter: observe the values present at the edge,
    // then update the driven inputs 1 time unit later.
    always @(posedge clk) begin
        logic [NUM_REQ-1:0] seenReady;
        logic               seenStart;
        logic               seenRst;
        seenReady = req_ready;
        seenStart = tx_start;
        seenRst   = rst;
        #1;
        if (seenRst === 1'b1) begin
            busyLeft = 0;
        end else if (seenStart === 1'b1 && busyEnable) begin
            busyLeft = BUSY_LEN;
        end else if (busyLeft > 0) begin
            busyLeft--;
        end
        tx_busy = (busyLeft > 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (seenReady[i] === 1'b1 && reqQ[i].size() > 0) begin
                void'(reqQ[i].pop_front());
                gapLeft[i] = gapMode ? int'($urandom_range(0, 2)) : 0;
            end else if (gapLeft[i] > 0) begin
                gapLeft[i]--;
            end
        end
        applyStimulus();
    end

    // Behavioural model: a grant is a record (holder, bytes sent, last flag,
    // edge number of the launch, whether busy was seen). Timing is derived
    // from edge numbers relative to the launch edge.
    int          edgeNo = 0;
    bit          mActive = 1'b0;
    int          mHolder = 0;
    int          mPtr = 0;
    int          mCount = 0;
    int          mLaunchEdge = 0;
    bit          mLast = 1'b0;
    bit          mAcked = 1'b0;
    logic        expStart = 1'b0;
    logic        expActive = 1'b0;
    logic        expAckErr = 1'b0;
    logic [3:0]  expReady = '0;
    logic [7:0]  expData = '0;
    logic [1:0]  expGid = '0;

    task automatic modelLaunch(input int w);
        expGid      = 2'(w);
        expActive   = 1'b1;
        expData     = req_data[w*DATA_W +: DATA_W];
        mLast       = req_last[w];
        expStart    = 1'b1;
        expReady    = 4'(1 << w);
        mLaunchEdge = edgeNo;
        mAcked      = 1'b0;
    endtask

    task automatic modelRelease();
        mActive   = 1'b0;
        expActive = 1'b0;
        mPtr      = (mHolder + 1) % NUM_REQ;
    endtask

    always @(posedge clk) begin
        int w;
        int idx;
        if (rst === 1'b1) begin
            mActive = 1'b0; mPtr = 0; mCount = 0; mAcked = 1'b0; mLast = 1'b0;
            expStart = 1'b0; expReady = '0; expData = '0; expGid = '0;
            expActive = 1'b0; expAckErr = 1'b0;
        end else begin
            expStart  = 1'b0;
            expReady  = '0;
            expAckErr = 1'b0;
            if (!mActive) begin
                w = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (mPtr + k) % NUM_REQ;
                    if (w < 0 && req_valid[idx] === 1'b1) w = idx;
                end
                if (w >= 0) begin
                    mActive = 1'b1;
                    mHolder = w;
                    mCount  = 1;
                    modelLaunch(w);
                end
            end else if (edgeNo == mLaunchEdge + 1) begin
                mAcked = 1'b0;
            end else if (!mAcked) begin
                if (tx_busy) begin
                    mAcked = 1'b1;
                end else if (edgeNo - mLaunchEdge - 1 == ACK_TO) begin
                    expAckErr = 1'b1;
                    modelRelease();
                end
            end else if (!tx_busy) begin
                if (req_valid[mHolder] === 1'b1 && !mLast && mCount < MAX_BURST) begin
                    mCount++;
                    modelLaunch(mHolder);
                end else begin
                    modelRelease();
                end
            end
        end
        edgeNo++;
    end

    // Compare process plus a log of launches and ack errors used by the
    // directed scenarios.
    bit   checkEn = 1'b0;
    int   cyc = 0;
    int   logGid [$];
    int   logData [$];
    int   logCyc [$];
    int   ackCyc [$];
    int   ackActive [$];

    always @(negedge clk) begin
        cyc++;
        if (checkEn) begin
            checkOutput("tx_start", 32'(tx_start), 32'(expStart));
            checkOutput("req_ready", 32'(req_ready), 32'(expReady));
            checkOutput("tx_data", 32'(tx_data), 32'(expData));
            checkOutput("grant_id", 32'(grant_id), 32'(expGid));
            checkOutput("active", 32'(active), 32'(expActive));
            checkOutput("ack_err", 32'(ack_err), 32'(expAckErr));
            if (tx_start === 1'b1) begin
                logGid.push_back(int'(grant_id));
                logData.push_back(int'(tx_data));
                logCyc.push_back(cyc);
            end
            if (ack_err === 1'b1) begin
                ackCyc.push_back(cyc);
                ackActive.push_back(int'(active));
            end
        end
    end

    function automatic bit allEmpty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reqQ[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int gidAt(input int i);
        return (logGid.size() > i) ? logGid[i] : 255;
    endfunction

    function automatic int dataAt(input int i);
        return (logData.size() > i) ? logData[i] : 511;
    endfunction

    function automatic int cycAt(input int i);
        return (logCyc.size() > i) ? logCyc[i] : -1000;
    endfunction

    task automatic clearLogs();
        logGid.delete(); logData.delete(); logCyc.delete();
        ackCyc.delete(); ackActive.delete();
    endtask

    task automatic waitQuiet(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(allEmpty() && active === 1'b0 && tx_busy === 1'b0) && n < budget);
        if (n >= budget) failNow(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s;
        int r;
        int len;
        for (int i = 0; i < NUM_REQ; i++) gapLeft[i] = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset_active", 32'(active), 32'd0);
        checkOutput("reset_tx_start", 32'(tx_start), 32'd0);
        checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
        rst = 1'b0;

        // Single byte from requester 2, then pointer must favour requester 3.
        reqQ[2].push_back({1'b1, 8'hA5});
        @(negedge clk);
        checkOutput("t1_valid", 32'(req_valid), 32'h4);
        checkOutput("t1_no_start_yet", 32'(tx_start), 32'd0);
        @(negedge clk);
        checkOutput("t1_start", 32'(tx_start), 32'd1);
        checkOutput("t1_data", 32'(tx_data), 32'hA5);
        checkOutput("t1_ready", 32'(req_ready), 32'h4);
        checkOutput("t1_gid", 32'(grant_id), 32'd2);
        checkOutput("t1_active", 32'(active), 32'd1);
        waitQuiet(100, "t1_wait");
        checkOutput("t1_released", 32'(active), 32'd0);
        checkOutput("t1_gid_kept", 32'(grant_id), 32'd2);
        clearLogs();
        reqQ[0].push_back({1'b1, 8'h10});
        reqQ[3].push_back({1'b1, 8'h13});
        waitQuiet(200, "t1_ptr_wait");
        checkOutput("t1_ptr_first", 32'(gidAt(0)), 32'd3);
        checkOutput("t1_ptr_second", 32'(gidAt(1)), 32'd0);

        // All four valid with last set: strict rotation from requester 0.
        doReset();
        clearLogs();
        reqQ[0].push_back({1'b1, 8'h20});
        reqQ[0].push_back({1'b1, 8'h24});
        reqQ[1].push_back({1'b1, 8'h21});
        reqQ[2].push_back({1'b1, 8'h22});
        reqQ[3].push_back({1'b1, 8'h23});
        waitQuiet(400, "t2_wait");
        checkOutput("t2_count", 32'(logGid.size()), 32'd5);
        checkOutput("t2_g0", 32'(gidAt(0)), 32'd0);
        checkOutput("t2_g1", 32'(gidAt(1)), 32'd1);
        checkOutput("t2_g2", 32'(gidAt(2)), 32'd2);
        checkOutput("t2_g3", 32'(gidAt(3)), 32'd3);
        checkOutput("t2_g4", 32'(gidAt(4)), 32'd0);

        // Burst of three from requester 1, then requester 0.
        clearLogs();
        reqQ[1].push_back({1'b0, 8'h11});
        reqQ[1].push_back({1'b0, 8'h22});
        reqQ[1].push_back({1'b1, 8'h33});
        reqQ[0].push_back({1'b1, 8'h44});
        waitQuiet(400, "t3_wait");
        checkOutput("t3_d0", 32'(dataAt(0)), 32'h11);
        checkOutput("t3_d1", 32'(dataAt(1)), 32'h22);
        checkOutput("t3_d2", 32'(dataAt(2)), 32'h33);
        checkOutput("t3_d3", 32'(dataAt(3)), 32'h44);
        checkOutput("t3_g3", 32'(gidAt(3)), 32'd0);
        checkOutput("t3_gap01", 32'(cycAt(1) - cycAt(0)), 32'd12);
        checkOutput("t3_gap12", 32'(cycAt(2) - cycAt(1)), 32'd12);
        checkOutput("t3_gap23", 32'(cycAt(3) - cycAt(2)), 32'd13);

        // Burst cap: requester 3 sends 4, requester 0 one, requester 3 resumes.
        clearLogs();
        for (int b = 0; b < 6; b++) reqQ[3].push_back({1'b0, 8'(8'hA0 + b)});
        reqQ[0].push_back({1'b1, 8'hB0});
        waitQuiet(600, "t4_wait");
        checkOutput("t4_count", 32'(logGid.size()), 32'd7);
        for (int b = 0; b < 4; b++) checkOutput("t4_cap_gid", 32'(gidAt(b)), 32'd3);
        checkOutput("t4_g4", 32'(gidAt(4)), 32'd0);
        checkOutput("t4_d4", 32'(dataAt(4)), 32'hB0);
        checkOutput("t4_g5", 32'(gidAt(5)), 32'd3);
        checkOutput("t4_d5", 32'(dataAt(5)), 32'hA4);
        checkOutput("t4_d6", 32'(dataAt(6)), 32'hA5);

        // Transmitter never answers: ack_err and release to next requester.
        busyEnable = 1'b0;
        clearLogs();
        reqQ[1].push_back({1'b1, 8'hC1});
        reqQ[2].push_back({1'b1, 8'hC2});
        waitQuiet(300, "t5_wait");
        checkOutput("t5_ack_count", 32'(ackCyc.size()), 32'd2);
        checkOutput("t5_g0", 32'(gidAt(0)), 32'd1);
        checkOutput("t5_g1", 32'(gidAt(1)), 32'd2);
        if (ackCyc.size() > 0) begin
            checkOutput("t5_ack_delay", 32'(ackCyc[0] - cycAt(0)), 32'(ACK_TO + 1));
            checkOutput("t5_ack_active", 32'(ackActive[0]), 32'd0);
        end else begin
            failNow("t5_no_ack");
        end
        checkOutput("t5_next_delay", 32'(cycAt(1) - cycAt(0)), 32'(ACK_TO + 2));
        busyEnable = 1'b1;

        // Reset during WAIT_DONE; arbitration must restart from requester 0.
        clearLogs();
        reqQ[1].push_back({1'b0, 8'hD0});
        reqQ[1].push_back({1'b1, 8'hD1});
        s = 0;
        while (tx_start !== 1'b1 && s < 20) begin
            @(negedge clk);
            s++;
        end
        if (s >= 20) failNow("t6_first_start");
        checkOutput("t6_first_gid", 32'(grant_id), 32'd1);
        repeat (4) @(negedge clk);
        reqQ[3].push_back({1'b1, 8'hE0});
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_rst_active", 32'(active), 32'd0);
        checkOutput("t6_rst_start", 32'(tx_start), 32'd0);
        checkOutput("t6_rst_ready", 32'(req_ready), 32'd0);
        checkOutput("t6_rst_data", 32'(tx_data), 32'd0);
        checkOutput("t6_rst_gid", 32'(grant_id), 32'd0);
        clearLogs();
        rst = 1'b0;
        waitQuiet(300, "t6_wait");
        checkOutput("t6_after_g0", 32'(gidAt(0)), 32'd1);
        checkOutput("t6_after_d0", 32'(dataAt(0)), 32'hD1);
        checkOutput("t6_after_g1", 32'(gidAt(1)), 32'd3);

        // Randomized traffic with hold-off gaps, a silent-transmitter window
        // and occasional resets; the compare process checks every cycle.
        gapMode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            busyEnable = !(c >= 1000 && c < 1150);
            if ($urandom_range(0, 99) < 8) begin
                r = int'($urandom_range(0, NUM_REQ - 1));
                if (reqQ[r].size() < 8) begin
                    len = int'($urandom_range(1, 6));
                    for (int b = 0; b < len; b++) begin
                        reqQ[r].push_back({(b == len - 1) ? ($urandom_range(0, 9) < 7)
                                                         : ($urandom_range(0, 9) == 0),
                                           8'($urandom)});
                    end
                end
            end
            if ($urandom_range(0, 999) < 2) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        busyEnable = 1'b1;
        waitQuiet(4000, "random_drain");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
